spike_input_frontend: RTL
=========================

Name: spike_input_frontend

Overview:
- Parametrised successor to the fixed 3-channel spike input path (per-bit 2-flop synchronizers plus a gated 3-bit register) that feeds the RSNN core.
- Synchronizes NUM_CH asynchronous spike lines and the system/capture enables through SYNC_STAGES flops.
- Optionally converts levels to single-cycle rising-edge pulses and registers the result for the network.
- Keeps per-channel saturating spike counters with sticky overflow flags for chip debug.

Parameters:
NUM_CH, 3, number of spike input channels (>=1)
SYNC_STAGES, 2, synchronizer depth applied to every async input (>=2)
CNT_W, 8, width of each per-channel spike counter (>=2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
system_enable  input  1  asynchronous global enable; synchronized internally
capture_enable  input  1  asynchronous capture enable; synchronized internally
edge_mode  input  1  quasi-static mode select; 0 = level, 1 = rising-edge pulse; not synchronized
async_spikes  input  NUM_CH  asynchronous spike inputs
count_clear  input  1  synchronous, level-sensitive clear of counters and overflow flags
spikes_out  output  NUM_CH  registered spikes to the RSNN core
spikes_valid  output  1  high in each cycle spikes_out was updated
spike_counts  output  NUM_CH*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W]
overflow  output  NUM_CH  sticky per-channel saturation flag

Behaviour:
- Reset: reset_n sampled low at a rising clk edge clears every flop in the block, including all sync stages, edge history, spikes_out, spikes_valid, spike_counts and overflow. All outputs are 0 in the cycle after the reset edge. Reset asserted mid-operation aborts everything with no partial state retained.
- Synchronizers:
  - Each async_spikes bit, system_enable and capture_enable passes through its own SYNC_STAGES-deep flop chain. The chain output is sync_x.
  - Chains always shift, independent of any enable.
- Edge history: prev[i] <= sync_spk[i] every cycle. This register is always updated.
- Detect:
  - edge_mode=0: det[i] = sync_spk[i].
  - edge_mode=1: det[i] = sync_spk[i] & ~prev[i].
  - A held-high input gives exactly one pulse in edge mode.
  - A toggle of edge_mode takes effect in the same cycle. Software changes it only while capture is off.
- Capture condition: cap = sync_sys_en & sync_cap_en.
  - cap=1: spikes_out <= det and spikes_valid <= 1.
  - cap=0: spikes_out holds its last value and spikes_valid <= 0.
- Latency: an async_spikes edge set up before clk edge k appears on spikes_out after edge k+SYNC_STAGES (level mode, cap already 1). The same holds for edge-mode pulses, because det is combinational from sync and prev.
- Enable latency: a change on system_enable or capture_enable affects cap SYNC_STAGES cycles later.
- Counters, per channel:
  - count_clear=1: count[i] <= 0 and overflow[i] <= 0. This works regardless of cap and takes priority over an increment in the same cycle.
  - Otherwise, if cap & det[i]:
    - count[i] < 2^CNT_W-1: count[i] <= count[i]+1.
    - count[i] already 2^CNT_W-1: count holds (saturate, no wrap) and overflow[i] <= 1.
  - Otherwise count and overflow hold.
  - overflow stays set until count_clear or reset.
- Simultaneous events: clear and spike in the same cycle leaves count 0. Channels are fully independent.
- System disable (sync_sys_en=0): only the sync chains and prev advance; spikes_out, counts and overflow are frozen, except for count_clear.

Test Plan:
- Reset: hold reset_n=0 two cycles with all inputs toggling (NUM_CH=3, SYNC_STAGES=2, CNT_W=4) -> every output 0; the first cycle after release keeps spikes_out=000.
- Level latency: enables high long enough, async_spikes 000->101 before edge k -> spikes_out=101 after edge k+2, spikes_valid=1 continuously; counts for ch0 and ch2 increment every cycle while held.
- Edge mode: edge_mode=1, ch1 held high 10 cycles -> spikes_out[1] high for exactly one cycle; count[1]=1; a second rising edge -> count[1]=2.
- Saturation: CNT_W=4, 20 pulses on ch0 -> count[0]=15, overflow[0] asserts on the 16th pulse, other channels unaffected; count_clear one cycle -> count[0]=0, overflow[0]=0.
- Clear priority: count_clear high in the same cycle as a captured pulse -> count 0 next cycle, not 1.
- Enable gating: drop capture_enable -> spikes_valid low 2 cycles later, spikes_out frozen, counts frozen during spikes; drop system_enable with capture_enable high -> same result; count_clear still clears while disabled.

Source files
------------

// File: rtl/spike_input_frontend.sv
// Spike input front end: synchronizes async spike lines and enables, optionally
// converts levels to rising-edge pulses, registers spikes for the RSNN core and
// keeps per-channel saturating debug counters with sticky overflow flags.
module spike_input_frontend #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      system_enable,
    input  logic                      capture_enable,
    input  logic                      edge_mode,
    input  logic [NUM_CH-1:0]         async_spikes,
    input  logic                      count_clear,
    output logic [NUM_CH-1:0]         spikes_out,
    output logic                      spikes_valid,
    output logic [NUM_CH*CNT_W-1:0]   spike_counts,
    output logic [NUM_CH-1:0]         overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0]      spk_pipe [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sys_pipe;
    logic [SYNC_STAGES-1:0] cap_pipe;
    logic [NUM_CH-1:0]      prev;
    logic [CNT_W-1:0]       count [NUM_CH];

    logic [NUM_CH-1:0]      sync_spk;
    logic                   sync_sys_en;
    logic                   sync_cap_en;
    logic [NUM_CH-1:0]      det;
    logic                   cap;

    assign sync_spk    = spk_pipe[SYNC_STAGES-1];
    assign sync_sys_en = sys_pipe[SYNC_STAGES-1];
    assign sync_cap_en = cap_pipe[SYNC_STAGES-1];

    // Synchronizer chains; they shift every cycle regardless of the enables
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                spk_pipe[s] <= '0;
            end
            sys_pipe <= '0;
            cap_pipe <= '0;
        end else begin
            spk_pipe[0] <= async_spikes;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                spk_pipe[s] <= spk_pipe[s-1];
            end
            sys_pipe <= {sys_pipe[SYNC_STAGES-2:0], system_enable};
            cap_pipe <= {cap_pipe[SYNC_STAGES-2:0], capture_enable};
        end
    end

    // Edge history for rising-edge detection, always tracking the synced lines
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync_spk;
        end
    end

    // Level or rising-edge detection and the combined capture condition
    always_comb begin
        det = sync_spk;
        if (edge_mode) begin
            det = sync_spk & ~prev;
        end
        cap = sync_sys_en & sync_cap_en;
    end

    // Output register: updated only while capturing, otherwise holds
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spikes_out   <= '0;
            spikes_valid <= 1'b0;
        end else begin
            spikes_valid <= cap;
            if (cap) begin
                spikes_out <= det;
            end
        end
    end

    // Saturating per-channel counters; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                count[i] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (count_clear) begin
                    count[i]    <= '0;
                    overflow[i] <= 1'b0;
                end else if (cap && det[i]) begin
                    if (count[i] == CNT_MAX) begin
                        overflow[i] <= 1'b1;
                    end else begin
                        count[i] <= count[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Flatten counters onto the debug bus
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign spike_counts[g*CNT_W +: CNT_W] = count[g];
    end

endmodule
